// File: rtl/sa_feeder_if.sv
// sa_feeder_if: weight-row and activation-vector valid/ready streams feeding
// the systolic-array edge driver.
//   w_valid/w_ready/w_row : one weight row per beat, lane c -> column c
//   a_valid/a_ready/a_vec : one activation vector per beat, lane r -> row r
// master = producer of rows/vectors, slave = sa_feeder.
interface sa_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4
) ();

  logic                       w_valid;
  logic                       w_ready;
  logic [COLS*DATA_WIDTH-1:0] w_row;
  logic                       a_valid;
  logic                       a_ready;
  logic [ROWS*DATA_WIDTH-1:0] a_vec;

  modport master (
    output w_valid, w_row, a_valid, a_vec,
    input  w_ready, a_ready
  );

  modport slave (
    input  w_valid, w_row, a_valid, a_vec,
    output w_ready, a_ready
  );

endinterface

// File: rtl/sa_feeder.sv
// sa_feeder: edge driver for a weight-stationary systolic array.
// Loads ROWS weight rows into the top edge, then streams N activation vectors
// into the left edge with a per-row skew, followed by a zero drain, and flags
// when each column's bottom partial sum is a finished result.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : job start pulse (ignored while busy_o)
//   load_w_i        : load weights before compute (latched at start)
//   num_vec_i       : vector count N (latched at start)
//   busy_o, done_o  : job in flight / one-cycle end-of-job pulse
//   mode_ctrl_o     : PE mode broadcast (00 freeze, 01 load, 10 compute)
//   weight_top_o    : weights into row 0
//   data_left_o     : skewed activations into column 0
//   res_valid_o     : per-column result-valid strobe
//   bus             : weight/activation streams (slave side)
module sa_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       load_w_i,
  input  logic [CNT_WIDTH-1:0]       num_vec_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [1:0]                 mode_ctrl_o,
  output logic [COLS*DATA_WIDTH-1:0] weight_top_o,
  output logic [ROWS*DATA_WIDTH-1:0] data_left_o,
  output logic [COLS-1:0]            res_valid_o,
  sa_feeder_if.slave                 bus
);

  localparam int unsigned KW  = CNT_WIDTH + 1;
  localparam int unsigned WCW = $clog2(ROWS) + 1;
  localparam int unsigned WW  = COLS * DATA_WIDTH;
  localparam int unsigned VW  = ROWS * DATA_WIDTH;

  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_LOAD = 2'b01;
  localparam logic [1:0] M_COMP = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [KW-1:0]        k_q, k_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [WW-1:0]        wt_q, wt_d;
  logic [COLS-1:0]      rv_q, rv_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 feed;
  logic                 step;
  logic [KW-1:0]        last_k;
  logic [VW-1:0]        in_vec;

  // feed: still taking real vectors; afterwards every compute cycle is a drain step
  assign feed    = (k_q < KW'(n_q));
  assign last_k  = KW'(n_q) + KW'(ROWS + COLS - 2);
  assign step    = (state_q == S_COMPUTE) && (!feed || bus.a_valid);
  assign in_vec  = feed ? bus.a_vec : '0;

  assign bus.w_ready = (state_q == S_LOAD);
  assign bus.a_ready = (state_q == S_COMPUTE) && feed;

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign mode_ctrl_o  = mode_q;
  assign weight_top_o = wt_q;
  assign res_valid_o  = rv_q;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      wcnt_q  <= '0;
      mode_q  <= M_IDLE;
      wt_q    <= '0;
      rv_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      mode_q  <= mode_d;
      wt_q    <= wt_d;
      rv_q    <= rv_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next state and next registered outputs.
  // S_DONE is the cycle showing the last array activity; done pulses after it.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    wcnt_d  = wcnt_q;
    mode_d  = M_IDLE;
    wt_d    = wt_q;
    rv_d    = '0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // done_q marks the end-of-job cycle, during which start is still ignored
        if (start_i && !done_q) begin
          n_d    = num_vec_i;
          k_d    = '0;
          wcnt_d = '0;
          if (load_w_i)              state_d = S_LOAD;
          else if (num_vec_i != '0)  state_d = S_COMPUTE;
          else                       state_d = S_DONE;
        end
      end
      S_LOAD: begin
        if (bus.w_valid) begin
          wt_d   = bus.w_row;
          mode_d = M_LOAD;
          if (wcnt_q == WCW'(ROWS - 1)) state_d = (n_q != '0) ? S_COMPUTE : S_DONE;
          else                          wcnt_d  = wcnt_q + WCW'(1);
        end
      end
      S_COMPUTE: begin
        if (step) begin
          mode_d = M_COMP;
          // column c finishes vector k-ROWS-c on this array cycle
          for (int unsigned c = 0; c < COLS; c++) begin
            rv_d[c] = (k_q >= KW'(ROWS + c)) && (k_q < KW'(n_q) + KW'(ROWS + c));
          end
          if (k_q == last_k) state_d = S_DONE;
          else               k_d     = k_q + KW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || done_d;
  end

  // Per-row skew: row r delays its lane by r extra steps; the top slot drives the array
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    localparam int unsigned SW = (r + 1) * DATA_WIDTH;
    logic [SW-1:0] sh_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)       sh_q <= '0;
      else if (step) sh_q <= SW'({sh_q, in_vec[r*DATA_WIDTH +: DATA_WIDTH]});
    end

    assign data_left_o[r*DATA_WIDTH +: DATA_WIDTH] = sh_q[SW-1 -: DATA_WIDTH];
  end

endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: randomized scoreboard bench for sa_feeder (4x4, 8-bit).
// The driver pushes every job's expected array-facing events (load beats,
// compute cycles, done) into a queue; a negedge monitor pops them whenever the
// DUT shows mode 01/10 or done, and checks holds while the array is frozen.
module tb_sa_feeder;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 4;

  typedef struct {
    int          kind;   // 1 load beat, 2 compute cycle, 3 done
    logic [31:0] d;
    logic [3:0]  rv;
    bit          act;
  } ev_t;

  logic        clk, rst, start, load_w, busy, done;
  logic [15:0] num_vec;
  logic [1:0]  mode_ctrl;
  logic [31:0] weight_top, data_left;
  logic [3:0]  res_valid;

  sa_feeder_if #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) bus ();

  sa_feeder #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .load_w_i(load_w), .num_vec_i(num_vec),
    .busy_o(busy), .done_o(done), .mode_ctrl_o(mode_ctrl), .weight_top_o(weight_top),
    .data_left_o(data_left), .res_valid_o(res_valid), .bus(bus.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  ev_t         q[$];
  ev_t         mon_e;
  logic [31:0] exp_wt = '0;
  logic [31:0] exp_dl = '0;
  logic [1:0]  prev_mode = 2'b00;

  logic [31:0] jw[R];
  int          wg[R];
  logic [31:0] jv[64];
  int          ag[64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected event stream of one job, straight from the skew/result-valid rules
  function automatic void push_job(input bit lw, input int n);
    ev_t e;
    e.act = 1'b0;
    if (lw) begin
      for (int b = 0; b < R; b++) begin
        e.kind = 1; e.d = jw[b]; e.rv = '0;
        q.push_back(e);
      end
    end
    if (n > 0) begin
      for (int j = 0; j < n + R + C - 1; j++) begin
        e.kind = 2; e.d = '0; e.rv = '0;
        for (int r = 0; r < R; r++)
          if (j - r >= 0 && j - r < n) e.d[r*DW +: DW] = jv[j-r][r*DW +: DW];
        for (int c = 0; c < C; c++)
          e.rv[c] = (j - R - c >= 0) && (j - R - c < n);
        q.push_back(e);
      end
    end
    e.kind = 3; e.d = '0; e.rv = '0; e.act = lw || (n > 0);
    q.push_back(e);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_mode = 2'b00;
    end else begin
      case (mode_ctrl)
        2'b01: begin
          if (q.size() == 0 || q[0].kind != 1) chk("unexpected_load_beat", 64'(1), 64'(0));
          else begin
            mon_e = q.pop_front();
            chk("weight_top", 64'(weight_top), 64'(mon_e.d));
            chk("res_valid_in_load", 64'(res_valid), 64'(0));
            exp_wt = mon_e.d;
          end
        end
        2'b10: begin
          if (q.size() == 0 || q[0].kind != 2) chk("unexpected_compute_cycle", 64'(1), 64'(0));
          else begin
            mon_e = q.pop_front();
            chk("data_left", 64'(data_left), 64'(mon_e.d));
            chk("res_valid", 64'(res_valid), 64'(mon_e.rv));
            exp_dl = mon_e.d;
          end
        end
        2'b00: begin
          chk("weight_top_hold", 64'(weight_top), 64'(exp_wt));
          chk("data_left_hold", 64'(data_left), 64'(exp_dl));
          chk("res_valid_frozen", 64'(res_valid), 64'(0));
        end
        default: chk("mode_ctrl_illegal", 64'(mode_ctrl), 64'(0));
      endcase
      if (done) begin
        if (q.size() == 0 || q[0].kind != 3) chk("unexpected_done", 64'(1), 64'(0));
        else begin
          mon_e = q.pop_front();
          chk("busy_with_done", 64'(busy), 64'(1));
          chk("mode_at_done", 64'(mode_ctrl), 64'(0));
          if (mon_e.act) chk("done_after_last_active", 64'(prev_mode != 2'b00), 64'(1));
        end
      end
      prev_mode = mode_ctrl;
    end
  end

  task automatic send_w(input logic [31:0] row);
    bit ok;
    ok = 1'b0;
    bus.w_valid = 1'b1;
    bus.w_row   = row;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = bus.w_ready;
      tick();
    end
    bus.w_valid = 1'b0;
    if (!ok) chk("w_ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_a(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    bus.a_valid = 1'b1;
    bus.a_vec   = v;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = bus.a_ready;
      tick();
    end
    bus.a_valid = 1'b0;
    bus.a_vec   = 32'($urandom);
    if (!ok) chk("a_ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 300 && busy; t++) tick();
    chk("job_completes", 64'(busy), 64'(0));
    tick();
  endtask

  // poke: pulse start with a different N during the gap before beat 1
  task automatic run_job(input bit lw, input int n, input bit poke);
    push_job(lw, n);
    start = 1'b1; load_w = lw; num_vec = 16'(n);
    tick();
    start = 1'b0; load_w = 1'($urandom); num_vec = 16'($urandom);
    if (lw) begin
      for (int b = 0; b < R; b++) begin
        for (int g = 0; g < wg[b]; g++) begin
          if (poke && b == 1 && g == 0) begin
            start = 1'b1; load_w = 1'b0; num_vec = 16'(7);
          end
          tick();
          start = 1'b0;
        end
        send_w(jw[b]);
      end
    end
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < ag[i]; g++) tick();
      send_a(jv[i]);
    end
    wait_idle();
  endtask

  task automatic clear_gaps();
    for (int b = 0; b < R; b++) wg[b] = 0;
    for (int i = 0; i < 64; i++) ag[i] = 0;
  endtask

  task automatic reset_mid_compute();
    logic [31:0] v;
    v = 32'($urandom);
    for (int i = 0; i < 5; i++) jv[i] = v;
    push_job(1'b0, 5);
    start = 1'b1; load_w = 1'b0; num_vec = 16'(5);
    bus.a_valid = 1'b1; bus.a_vec = v;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    q.delete();
    exp_wt = '0;
    exp_dl = '0;
    #1;
    chk("rst_mode_ctrl", 64'(mode_ctrl), 64'(0));
    chk("rst_weight_top", 64'(weight_top), 64'(0));
    chk("rst_data_left", 64'(data_left), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_a_ready", 64'(bus.a_ready), 64'(0));
    bus.a_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; load_w = 1'b0; num_vec = '0;
    bus.w_valid = 1'b0; bus.w_row = '0; bus.a_valid = 1'b0; bus.a_vec = '0;
    clear_gaps();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mode_ctrl", 64'(mode_ctrl), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_weight_top", 64'(weight_top), 64'(0));
    chk("reset_data_left", 64'(data_left), 64'(0));
    chk("reset_res_valid", 64'(res_valid), 64'(0));
    chk("reset_w_ready", 64'(bus.w_ready), 64'(0));
    chk("reset_a_ready", 64'(bus.a_ready), 64'(0));
    rst = 1'b0;
    tick();

    // load only, back-to-back rows (bottom row first)
    jw[0] = 32'h3333_3333; jw[1] = 32'h2222_2222; jw[2] = 32'h1111_1111; jw[3] = 32'h0A0B_0C0D;
    run_job(1'b1, 0, 1'b0);

    // compute, no stall: vectors {1,2,3,4},{5,6,7,8}
    jv[0] = 32'h0403_0201; jv[1] = 32'h0807_0605;
    run_job(1'b0, 2, 1'b0);

    // activation stall of 3 before the second vector
    ag[1] = 3;
    run_job(1'b0, 2, 1'b0);
    clear_gaps();

    // weight stall of 2 after the first beat, with a start poke inside the gap
    for (int b = 0; b < R; b++) jw[b] = 32'($urandom);
    wg[1] = 2;
    run_job(1'b1, 2, 1'b1);
    clear_gaps();

    // neither load nor vectors
    run_job(1'b0, 0, 1'b0);

    reset_mid_compute();

    // randomized jobs
    for (int jb = 0; jb < 20; jb++) begin
      bit lw;
      int n;
      lw = 1'($urandom_range(0, 1));
      n  = (jb == 7) ? 24 : int'($urandom_range(0, 6));
      for (int b = 0; b < R; b++) begin
        jw[b] = 32'($urandom);
        wg[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      for (int i = 0; i < n; i++) begin
        jv[i] = 32'($urandom);
        ag[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      run_job(lw, n, 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
